// File: rtl/gather_pkg.sv
// rtl/gather_pkg.sv - shared constants and helpers for rr_gather_arb (optional feature macro: RR_GATHER_LOCK_EN)
package gather_pkg;

  localparam int GATHER_WIDTH = 40;
  localparam int GATHER_N     = 4;

  // Tag width for n requesters; never narrower than one bit so N=1 still has a port
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GATHER_IW = idx_w(GATHER_N);

  typedef logic [GATHER_IW-1:0] gather_id_t;

endpackage

// File: rtl/rr_pointer_arb.sv
// rtl/rr_pointer_arb.sv - round-robin pointer and rotating priority encoder (optional feature macro: RR_GATHER_LOCK_EN)
module rr_pointer_arb
  import gather_pkg::*;
#(
  parameter int N  = GATHER_N,
  parameter int IW = idx_w(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
`ifdef RR_GATHER_LOCK_EN
  input  logic          lock,
`endif
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic [IW-1:0] ptr_next;
  logic [N-1:0]  elig;

`ifdef RR_GATHER_LOCK_EN
  logic lock_q, lock_d;

  // While locked, ptr holds the owner and only the owner may be granted
  always_comb begin
    elig = lock_q ? (req & (N'(1) << ptr_q)) : req;
  end
`else
  // Without locking every valid requester is eligible
  always_comb begin
    elig = req;
  end
`endif

  // Rotating search: first eligible index starting at ptr, wrapping modulo N
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!grant_any && (((elig >> cand) & N'(1)) != '0)) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    grant = grant_any ? (N'(1) << grant_idx) : '0;
  end

  // Pointer moves just past the winner; wraps at N-1 so non-power-of-two N works
  always_comb begin
    ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    ptr_d    = ptr_q;
`ifdef RR_GATHER_LOCK_EN
    lock_d = lock_q;
    if (advance && grant_any) begin
      if (lock) begin
        lock_d = 1'b1;
        ptr_d  = grant_idx;
      end else begin
        lock_d = 1'b0;
        ptr_d  = ptr_next;
      end
    end
`else
    if (advance && grant_any) begin
      ptr_d = ptr_next;
    end
`endif
  end

  // Pointer state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifdef RR_GATHER_LOCK_EN
  // Lock flag register; reset releases any packet in progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

endmodule

// File: rtl/rr_gather_arb.sv
// rtl/rr_gather_arb.sv - N-way round-robin gather into one output register (optional feature macro: RR_GATHER_LOCK_EN)
module rr_gather_arb
  import gather_pkg::*;
#(
  parameter int width = GATHER_WIDTH,
  parameter int N     = GATHER_N,
  parameter int IW    = idx_w(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N*width-1:0] m_data,
  input  logic [N-1:0]       m_valid,
`ifdef RR_GATHER_LOCK_EN
  input  logic [N-1:0]       m_last,
  output logic               s_last,
`endif
  output logic [N-1:0]       m_ready,
  output logic [width-1:0]   s_data,
  output logic [IW-1:0]      s_id,
  output logic               s_valid,
  input  logic               s_ready
);

  logic             s_valid_q;
  logic [width-1:0] data_q, data_d;
  logic [IW-1:0]    id_q;
  logic             load_ok;
  logic             load;
  logic [N-1:0]     grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;

  assign load_ok = !s_valid_q || s_ready;
  assign load    = load_ok && grant_any;

`ifdef RR_GATHER_LOCK_EN
  logic last_q, last_d;
  logic beat_lock;

  assign beat_lock = ((m_last & grant) == '0);
`endif

  rr_pointer_arb #(
    .N  (N),
    .IW (IW)
  ) u_ptr_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (m_valid),
    .advance   (load),
`ifdef RR_GATHER_LOCK_EN
    .lock      (beat_lock),
`endif
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready only to the winner, only when the register can take it, never during reset
  always_comb begin
    m_ready = reset ? '0 : (grant & {N{load_ok}});
  end

  // One-hot payload select from the winning requester slice
  always_comb begin
    data_d = '0;
`ifdef RR_GATHER_LOCK_EN
    last_d = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        data_d = m_data[i*width +: width];
`ifdef RR_GATHER_LOCK_EN
        last_d = m_last[i];
`endif
      end
    end
  end

  // Valid flag: refills or empties whenever the register drains; reset drops the held beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_valid_q <= 1'b0;
    end else if (load_ok) begin
      s_valid_q <= grant_any;
    end
  end

  // Payload and tag carry no reset; they are only meaningful while s_valid is high
  always_ff @(posedge clock) begin
    if (load) begin
      data_q <= data_d;
      id_q   <= grant_idx;
`ifdef RR_GATHER_LOCK_EN
      last_q <= last_d;
`endif
    end
  end

  assign s_valid = s_valid_q;
  assign s_data  = data_q;
  assign s_id    = id_q;
`ifdef RR_GATHER_LOCK_EN
  assign s_last  = last_q;
`endif

endmodule

// File: tb/tb_rr_gather_arb.sv
// tb/tb_rr_gather_arb.sv - scoreboard bench for rr_gather_arb (optional feature macro: RR_GATHER_LOCK_EN)
module tb_rr_gather_arb;

  localparam int W  = 40;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N*W-1:0] m_data;
  logic [N-1:0]   m_valid;
  logic [N-1:0]   m_ready;
  logic [W-1:0]   s_data;
  logic [IW-1:0]  s_id;
  logic           s_valid;
  logic           s_ready;
`ifdef RR_GATHER_LOCK_EN
  logic [N-1:0]   m_last;
  logic           s_last;
`endif

  always #5 clock = ~clock;

  rr_gather_arb #(.width(W), .N(N), .IW(IW)) dut (
    .clock   (clock),
    .reset   (reset),
    .m_data  (m_data),
    .m_valid (m_valid),
`ifdef RR_GATHER_LOCK_EN
    .m_last  (m_last),
    .s_last  (s_last),
`endif
    .m_ready (m_ready),
    .s_data  (s_data),
    .s_id    (s_id),
    .s_valid (s_valid),
    .s_ready (s_ready)
  );

  typedef struct {
    logic [W-1:0] data;
    int           id;
    bit           last;
  } beat_t;

  beat_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  // Reference model: rotating priority start, optional packet owner, output occupancy
  int mdl_ptr   = 0;
  int mdl_owner = -1;
  bit mdl_full  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mdl_grant(input logic [N-1:0] mv);
    if (mdl_owner >= 0) return mv[mdl_owner] ? mdl_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (mv[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic mdl_reset();
    mdl_ptr   = 0;
    mdl_owner = -1;
    mdl_full  = 1'b0;
    sb.delete();
  endtask

  task automatic cycle(input logic [N-1:0] mv, input bit sr, input logic [N-1:0] ml,
                       input logic [W-1:0] fill, input bit use_fill);
    int           g;
    bit           load_ok;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    @(negedge clock);
    m_valid = mv;
    s_ready = sr;
    for (int i = 0; i < N; i++) begin
      m_data[i*W +: W] = use_fill ? fill : W'({$urandom, $urandom});
    end
`ifdef RR_GATHER_LOCK_EN
    m_last = ml;
`endif
    #1;
    load_ok = !mdl_full || sr;
    g       = mdl_grant(mv);
    exp_rdy = (load_ok && g >= 0) ? (N'(1) << g) : '0;
    check("m_ready", 64'(m_ready), 64'(exp_rdy));
    if (g >= 0) begin
      b.data = m_data[g*W +: W];
      b.id   = g;
      b.last = ml[g];
    end
    @(posedge clock);
    if (load_ok) begin
      if (g >= 0) begin
        sb.push_back(b);
        mdl_full = 1'b1;
`ifdef RR_GATHER_LOCK_EN
        if (!ml[g]) begin
          mdl_owner = g;
        end else begin
          mdl_owner = -1;
          mdl_ptr   = (g + 1) % N;
        end
`else
        mdl_ptr = (g + 1) % N;
`endif
      end else begin
        mdl_full = 1'b0;
      end
    end
  endtask

  // Monitor: compares the held beat against the scoreboard head, pops on handshake
  always @(negedge clock) begin
    #2;
    if (checking) begin
      check("s_valid", 64'(s_valid), 64'(sb.size() > 0));
      if (sb.size() > 0) begin
        check("s_data", 64'(s_data), 64'(sb[0].data));
        check("s_id", 64'(s_id), 64'(sb[0].id));
`ifdef RR_GATHER_LOCK_EN
        check("s_last", 64'(s_last), 64'(sb[0].last));
`endif
        if (s_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset   = 1'b1;
    m_valid = '1;
    s_ready = 1'b1;
    m_data  = '0;
`ifdef RR_GATHER_LOCK_EN
    m_last  = '1;
`endif
    #1;
    check("reset_s_valid", 64'(s_valid), 64'(0));
    check("reset_m_ready", 64'(m_ready), 64'(0));
    @(negedge clock);
    m_valid = '0;
    @(negedge clock);
    reset    = 1'b0;
    mdl_reset();
    checking = 1'b1;

    // All-valid fairness: 0,1,2,3,0,1,2,3 back to back
    for (int i = 0; i < 8; i++) cycle(4'hF, 1'b1, 4'hF, '0, 1'b0);

    // Skip idle requesters starting from ptr=1: 2,0,2
    cycle(4'b0001, 1'b1, 4'hF, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0101, 1'b1, 4'hF, '0, 1'b0);

    // Backpressure on a known payload, then drain with same-cycle refill
    cycle(4'b0010, 1'b1, 4'hF, 40'hA5A5A5A5A5, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'hF, 1'b0, 4'hF, '0, 1'b0);
    cycle(4'hF, 1'b1, 4'hF, '0, 1'b0);

    // Mid-stream reset while stalled
    cycle(4'hF, 1'b0, 4'hF, '0, 1'b0);
    cycle(4'hF, 1'b0, 4'hF, '0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_s_valid", 64'(s_valid), 64'(0));
    check("midrst_m_ready", 64'(m_ready), 64'(0));
    mdl_reset();
    m_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    cycle(4'hF, 1'b1, 4'hF, '0, 1'b0);

`ifdef RR_GATHER_LOCK_EN
    // Packet lock: requester 1 sends last=0,0,1, then arbitration resumes at 2
    mdl_reset();
    @(negedge clock);
    reset = 1'b1;
    m_valid = '0;
    #1;
    @(negedge clock);
    reset = 1'b0;
    cycle(4'b0001, 1'b1, 4'hF, '0, 1'b0);
    cycle(4'hF, 1'b1, 4'b1101, '0, 1'b0);
    cycle(4'hF, 1'b1, 4'b1101, '0, 1'b0);
    cycle(4'hF, 1'b1, 4'hF, '0, 1'b0);
    cycle(4'hF, 1'b1, 4'hF, '0, 1'b0);
`endif

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom), ($urandom_range(0, 3) != 0), N'($urandom | $urandom), '0, 1'b0);
    end
    cycle('0, 1'b1, 4'hF, '0, 1'b0);
    cycle('0, 1'b1, 4'hF, '0, 1'b0);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_gather_arb.md
Name: rr_gather_arb

Overview:
- N-way round-robin arbiter plus single output register.
- Shares one downstream consumer (e.g. a solver or result path) among N independent valid/ready producers.
- Fair, work-conserving replacement for fixed-toggle 2:1 gathering.
- Sustains one transfer per cycle; tags each output beat with the source index.

Parameters:
- width, 40, payload bits per beat.
- N, 4, number of requesters; legal range 1..16.
- IW, $clog2(N) (minimum 1), width of source-index tag.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- m_data  input  N*width  requester payloads; requester i occupies bits [i*width +: width].
- m_valid  input  N  per-requester valid.
- m_ready  output  N  per-requester ready; at most one bit set.
- s_data  output  width  registered payload.
- s_id  output  IW  registered index of the source requester.
- s_valid  output  1  output register holds a beat.
- s_ready  input  1  downstream accepts.

Behaviour:
- Single-entry output register: buffer, id, valid.
- Round-robin pointer ptr (IW bits) names the highest-priority requester.
- Reset (async, active-high): s_valid=0, ptr=0. s_data and s_id are don't-care and are not reset.
- A reset asserted mid-transfer discards the held beat; no m_ready is asserted while reset is high.
- load_ok = !s_valid || s_ready, so the register is free or draining this cycle.
- Grant: g is the first index i with m_valid[i]=1, searched ptr, ptr+1, ... mod N.
- m_ready[g] = load_ok and any m_valid. All other m_ready bits are 0.
- m_ready depends combinationally on m_valid and s_ready. Producers must not make m_valid depend on m_ready.
- On a clock edge with load_ok and a grant:
  - buffer <= slice g of m_data, id <= g, s_valid <= 1.
  - ptr <= g+1, wrapping to 0 when g=N-1.
- On a clock edge with load_ok and no valid requester: s_valid <= 0 and ptr is unchanged.
- When s_valid && !s_ready:
  - buffer, id, s_valid and ptr hold; all m_ready bits are 0.
  - s_data and s_id stay stable until accepted.
- Latency: a beat accepted on edge k appears at s_* immediately after edge k.
- Throughput: with s_ready held at 1, one beat transfers per cycle with no bubbles.
- Fairness: with all N requesters continuously valid, grants cycle 0,1,...,N-1,0,... Each requester waits at most N-1 grants.
- N=1: ptr is constant 0 and the block behaves as a one-stage register slice.

Optional Feature:
- Macro RR_GATHER_LOCK_EN.
- When defined:
  - Adds input port m_last [N], sampled together with the granted beat.
  - If the accepted beat has m_last[g]=0, the arbiter locks to g: later grants go only to g, even if g is idle, until a beat with m_last=1 is accepted.
  - ptr advances to g+1 only on the m_last=1 beat.
  - Adds output s_last (1 bit), registered with the beat.
  - Reset clears the lock.
- When undefined: no m_last or s_last ports; every beat is arbitrated independently.

Decomposition:
- Package gather_pkg holds:
  - Default width constant GATHER_WIDTH=40.
  - Function idx_w(n) returning max(1, $clog2(n)).
  - Typedef for the source-index tag at the default N.
- Natural sub-module rr_pointer_arb:
  - Holds the pointer register and the rotate/priority-encode logic.
  - Inputs: req[N], advance, and (feature on) lock.
  - Outputs: one-hot grant[N] and binary grant index.
- rr_gather_arb instantiates rr_pointer_arb and adds the output register.

Test Plan:
- Reset behaviour: assert reset with all m_valid=1 -> s_valid=0 and m_ready=0. After release, first grant goes to index 0 with s_id=0.
- All-valid fairness: N=4, all m_valid=1, s_ready=1 for 8 cycles -> s_id sequence 0,1,2,3,0,1,2,3; one beat per cycle.
- Skip idle requesters: only m_valid[2] and m_valid[0] set, ptr=1 -> grant 2, then 0, then 2.
- Backpressure: s_ready=0 for 5 cycles while holding payload 0xA5A5A5A5A5 -> s_data and s_id stable, m_ready=0. Release -> next grant follows in the same cycle as the drain.
- Mid-stream reset: reset while s_valid=1 and s_ready=0 -> s_valid drops immediately (async). Next grant goes to index 0.
- With RR_GATHER_LOCK_EN: requester 1 sends 3 beats with m_last=0,0,1 while all requesters are valid -> s_id=1,1,1, then 2.
